// File: rtl/io_channel_unit.sv
// io_channel_unit: responder end of the core I/O channel bus.
// Holds 8 input channels, 7 output channels and a status word. Every core
// write to an output channel is queued and drained over a valid/ready stream.

// One input channel: value register plus its "updated" flag.
module io_in_slot (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        set,
   input  logic        clr,
   input  logic [14:0] d,
   output logic [14:0] q,
   output logic        upd
);

   // Latch a device update; a same-edge set beats the core's W1C clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q   <= '0;
         upd <= 1'b0;
      end else if (set) begin
         q   <= d;
         upd <= 1'b1;
      end else if (clr) begin
         upd <= 1'b0;
      end
   end

endmodule

module io_channel_unit #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  IO_read_sel,
   output logic [14:0] IO_read_data,
   input  logic        IO_write_en,
   input  logic [3:0]  IO_write_sel,
   input  logic [14:0] IO_write_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_chan,
   input  logic [14:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_chan,
   output logic [14:0] out_data
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0]  chan;
      logic [14:0] data;
   } fifo_ent_t;

   logic [7:0][14:0]        in_q;
   logic [7:0]              upd;
   logic [6:0][14:0]        out_q;
   fifo_ent_t [DEPTH-1:0]   mem;
   logic [PW-1:0]           rd_ptr, wr_ptr;
   logic [CNT_W-1:0]        count;
   logic                    ovf;
   logic [3:0]              cnt4;
   logic [14:0]             status;

   logic in_ack, wr_out, wr_stat, full, empty, pop, push_ok, ovf_set;

   assign in_ack  = in_valid & in_ready;
   // Output channels are 8..14; 15 is the status word, never queued
   assign wr_out  = IO_write_en & IO_write_sel[3] & (IO_write_sel != 4'hF);
   assign wr_stat = IO_write_en & (IO_write_sel == 4'hF);

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign pop     = out_valid & out_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept
   assign push_ok = wr_out & (~full | pop);
   assign ovf_set = wr_out & full & ~pop;

   // Input channel slots
   for (genvar g = 0; g < 8; g++) begin : g_in
      io_in_slot u_slot (
         .clock   (clock),
         .reset_n (reset_n),
         .set     (in_ack & (in_chan == 3'(g))),
         .clr     (wr_stat & IO_write_data[g]),
         .d       (in_data),
         .q       (in_q[g]),
         .upd     (upd[g])
      );
   end

   // Count field is always 4 bits wide in the status word
   if (CNT_W >= 4) begin : g_cnt_trunc
      assign cnt4 = count[3:0];
   end else begin : g_cnt_ext
      assign cnt4 = {{(4-CNT_W){1'b0}}, count};
   end

   assign status = {cnt4, ovf, full, empty, upd};

   // in_ready comes up on the first edge after reset and stays up
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) in_ready <= 1'b0;
      else          in_ready <= 1'b1;
   end

   // Output channel registers; updated even when the queue drops the word
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    out_q <= '0;
      else if (wr_out) out_q[IO_write_sel[2:0]] <= IO_write_data;
   end

   // Sticky overflow; a same-edge set beats the W1C clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                        ovf <= 1'b0;
      else if (ovf_set)                    ovf <= 1'b1;
      else if (wr_stat & IO_write_data[10]) ovf <= 1'b0;
   end

   // Circular FIFO; storage cleared on reset so the head reads 0 when empty
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= '{chan: IO_write_sel, data: IO_write_data};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head comes straight from storage: no path from the write port
   assign out_valid = ~empty;
   assign out_chan  = mem[rd_ptr].chan;
   assign out_data  = mem[rd_ptr].data;

   // Combinational read mux; returns pre-edge values (no write forwarding)
   always_comb begin
      IO_read_data = '0;
      if (IO_read_sel == 4'hF)  IO_read_data = status;
      else if (IO_read_sel[3])  IO_read_data = out_q[IO_read_sel[2:0]];
      else                      IO_read_data = in_q[IO_read_sel[2:0]];
   end

endmodule

// File: tb/tb_io_channel_unit.sv
// Directed bench for io_channel_unit with a small queue scoreboard for the
// output stream.
`timescale 1ns/1ps
module tb_io_channel_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  IO_read_sel;
   logic [14:0] IO_read_data;
   logic        IO_write_en;
   logic [3:0]  IO_write_sel;
   logic [14:0] IO_write_data;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_chan;
   logic [14:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_chan;
   logic [14:0] out_data;

   int n_tests = 0;
   int n_fail  = 0;
   logic [18:0] q[$];

   io_channel_unit #(.DEPTH(8), .CNT_W(4)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .IO_read_sel   (IO_read_sel),
      .IO_read_data  (IO_read_data),
      .IO_write_en   (IO_write_en),
      .IO_write_sel  (IO_write_sel),
      .IO_write_data (IO_write_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_chan       (in_chan),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_chan      (out_chan),
      .out_data      (out_data)
   );

   always #10 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input string tag, input logic [3:0] sel, input logic [14:0] exp);
      IO_read_sel = sel;
      #1;
      chk(tag, {17'd0, IO_read_data}, {17'd0, exp});
   endtask

   task automatic wr(input logic [3:0] sel, input logic [14:0] data);
      IO_write_en = 1'b1; IO_write_sel = sel; IO_write_data = data;
      tick();
      IO_write_en = 1'b0;
      if (sel >= 4'd8 && sel != 4'hF) q.push_back({sel, data});
   endtask

   // Check the head against the scoreboard, then pop it
   task automatic pop_chk(input string tag);
      logic [18:0] e;
      e = q.pop_front();
      chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_ch"}, {28'd0, out_chan}, {28'd0, e[18:15]});
      chk({tag, "_d"}, {17'd0, out_data}, {17'd0, e[14:0]});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; IO_read_sel = '0; IO_write_en = 1'b0; IO_write_sel = '0;
      IO_write_data = '0; in_valid = 1'b0; in_chan = '0; in_data = '0; out_ready = 1'b0;

      // Reset state
      #5;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      rd("rst_status", 4'hF, 15'h0100);
      #20 reset_n = 1'b1;
      tick();
      chk("in_ready_up", {31'd0, in_ready}, 32'd1);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Input update, W1C, and same-edge set vs clear
      in_valid = 1'b1; in_chan = 3'd3; in_data = 15'h1234;
      tick();
      in_valid = 1'b0;
      rd("ch3", 4'd3, 15'h1234);
      rd("upd3_set", 4'hF, 15'h0108);
      wr(4'hF, 15'h0008);
      rd("upd3_clr", 4'hF, 15'h0100);
      in_valid = 1'b1; in_data = 15'h0777;
      IO_write_en = 1'b1; IO_write_sel = 4'hF; IO_write_data = 15'h0008;
      tick();
      in_valid = 1'b0; IO_write_en = 1'b0;
      rd("set_wins", 4'hF, 15'h0108);
      rd("ch3_new", 4'd3, 15'h0777);
      wr(4'hF, 15'h00FF);
      rd("upd_all_clr", 4'hF, 15'h0100);

      // Output write, no forwarding, hold while stalled
      IO_write_en = 1'b1; IO_write_sel = 4'd9; IO_write_data = 15'h2AAA;
      rd("no_fwd", 4'd9, 15'h0000);
      tick();
      IO_write_en = 1'b0;
      q.push_back({4'd9, 15'h2AAA});
      rd("ch9", 4'd9, 15'h2AAA);
      rd("cnt1", 4'hF, 15'h0800);
      tick();
      chk("hold_ch", {28'd0, out_chan}, 32'd9);
      chk("hold_d", {17'd0, out_data}, 32'h2AAA);
      pop_chk("pop9");
      chk("drained_v", {31'd0, out_valid}, 32'd0);
      rd("drained_st", 4'hF, 15'h0100);

      // Fill, partial drain, refill across the pointer wrap
      for (int i = 0; i < 7; i++) wr(4'(8 + i), 15'(16'h0100 + i));
      wr(4'd8, 15'h0108);
      rd("full", 4'hF, 15'h4200);
      for (int i = 0; i < 3; i++) pop_chk("popA");
      wr(4'd9, 15'h0201);
      wr(4'd10, 15'h0202);
      wr(4'd11, 15'h0203);
      rd("full2", 4'hF, 15'h4200);

      // Overflow: word dropped, register still updated
      IO_write_en = 1'b1; IO_write_sel = 4'd10; IO_write_data = 15'h0055;
      tick();
      IO_write_en = 1'b0;
      rd("ovf_reg10", 4'd10, 15'h0055);
      rd("ovf_st", 4'hF, 15'h4600);
      wr(4'hF, 15'h0400);
      rd("ovf_clr", 4'hF, 15'h4200);

      // Full with simultaneous pop and push: both happen, no overflow
      chk("sim_ch", {28'd0, out_chan}, {28'd0, q[0][18:15]});
      chk("sim_d", {17'd0, out_data}, {17'd0, q[0][14:0]});
      void'(q.pop_front());
      out_ready = 1'b1;
      wr(4'd12, 15'h0333);
      out_ready = 1'b0;
      rd("sim_st", 4'hF, 15'h4200);

      // Drain everything in order
      for (int i = 0; i < 8; i++) pop_chk("drain");
      rd("empty_end", 4'hF, 15'h0100);
      chk("q_empty", q.size(), 32'd0);

      // Async reset mid-stream
      for (int i = 0; i < 5; i++) wr(4'(8 + i), 15'(16'h0400 + i));
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_chan = 3'(i); in_data = 15'(16'h0010 + i);
         tick();
      end
      in_valid = 1'b0;
      rd("pre_rst_st", 4'hF, 15'h28FF);
      #3 reset_n = 1'b0;
      #1;
      chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_out_chan", {28'd0, out_chan}, 32'd0);
      chk("ar_out_data", {17'd0, out_data}, 32'd0);
      chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
      rd("ar_status", 4'hF, 15'h0100);
      rd("ar_ch3", 4'd3, 15'h0000);
      rd("ar_ch8", 4'd8, 15'h0000);
      rd("ar_ch12", 4'd12, 15'h0000);
      q.delete();
      #20 reset_n = 1'b1;
      tick();
      chk("post_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_out_valid", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/io_channel_unit.md
Name: io_channel_unit

Overview:
- Responder end of the core's I/O channel bus. Serves combinational channel reads and accepts registered channel writes.
- Holds the channel register file:
  - channels 0–7: input, updated by external devices;
  - channels 8–14: output, written by the core;
  - channel 15: status.
- Every core write to an output channel is queued in a FIFO and drained to the external device side over a valid/ready stream.

Parameters:
- DEPTH, 8, output FIFO depth in entries (power of two, 2..16).
- CNT_W, 4, FIFO occupancy counter width; must hold 0..DEPTH.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- IO_read_sel  input  4  core read channel select
- IO_read_data  output  15  read data for IO_read_sel (combinational)
- IO_write_en  input  1  core write strobe
- IO_write_sel  input  4  core write channel select
- IO_write_data  input  15  core write data
- in_valid  input  1  external input-channel update request
- in_ready  output  1  unit accepts input update
- in_chan  input  3  target input channel 0–7
- in_data  input  15  new input-channel value
- out_valid  output  1  FIFO head valid
- out_ready  input  1  external sink accepts head
- out_chan  output  4  channel (8–14) of head entry
- out_data  output  15  data of head entry

Behaviour:
- Reset (async, reset_n=0):
  - channel registers 0–14 = 0; FIFO empty; status flags 0;
  - out_valid=0, out_chan=0, out_data=0, in_ready=0.
- After reset release: in_ready=1 constantly from the first clock edge onward.
- Reset mid-transfer discards FIFO contents and pending flags with no handshake completion.

Reads (combinational, zero latency):
- IO_read_data = register[IO_read_sel]; channel 15 returns the status word.
- A same-cycle write to the same channel is NOT forwarded; the read returns the pre-edge value.

Status word (channel 15):
- bits[7:0]: upd flags, one per input channel.
- bit8: fifo_empty.
- bit9: fifo_full (count==DEPTH).
- bit10: overflow, sticky.
- bits[14:11]: FIFO count (CNT_W bits, zero-extended/truncated to 4).

Core writes (take effect on the edge when IO_write_en=1):
- sel 0–7: ignored (input channels are read-only to the core).
- sel 8–14: register updated, and {sel, data} pushed to the FIFO.
- sel 15: write-1-to-clear. data bit k (k=0..7) clears upd[k]; data bit10 clears overflow; other bits ignored. Nothing is pushed.

Input updates:
- On an edge with in_valid & in_ready: register[in_chan] <= in_data and upd[in_chan] <= 1.
- A new value overwrites the old one; there is no queueing.
- Same-edge set and W1C clear of the same upd bit: set wins.

FIFO:
- Circular buffer with rd/wr pointers wrapping modulo DEPTH, plus a count.
- Head is presented on out_chan/out_data with out_valid = (count != 0). Outputs are driven directly from registered storage with no combinational path from IO_write_*.
- Pop on an edge with out_valid & out_ready.
- First-word latency: write accepted at edge N gives out_valid=1 immediately after edge N.
- Push when not full: accepted.
- Push when full with a simultaneous pop: both occur, count unchanged, no overflow.
- Push when full without a pop: data dropped, register still updated, overflow <= 1.
- Overflow set and W1C clear on the same edge: set wins.
- Entries drain in write order.
- out_chan/out_data hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then idle: IO_read_sel=15 → IO_read_data=0x0100 (empty=1); out_valid=0; in_ready=1 after the first edge.
- Input update: in_valid=1, in_chan=3, in_data=0x1234 for one edge → read ch3=0x1234 and ch15 bit3=1. Write ch15 data=0x0008 → bit3 clears. Repeat with update and clear on the same edge → bit3 stays 1.
- Output write: IO_write_en with sel=9, data=0x2AAA, out_ready=0 → ch9 reads 0x2AAA; out_valid=1, out_chan=9, out_data=0x2AAA held; count=1 (ch15 bits[14:11]=1). Raise out_ready for one edge → out_valid=0.
- FIFO ordering and wrap: out_ready=0, write sel 8..14 then 8 (8 entries, DEPTH=8) → full=1. Pop 3 and write 3 more, then drain with out_ready=1 → the 11 accepted words arrive in order; pointer wrap is exercised.
- Overflow: FIFO full, out_ready=0, write sel=10 data=0x0055 → reg10=0x0055, count stays 8, overflow=1. Full plus simultaneous pop and push → no overflow. Write ch15 data=0x0400 → overflow=0.
- Async reset mid-stream (FIFO holding 5 entries, upd=0xFF) → all outputs and registers read 0 immediately and status reads 0x0100.
